// File: rtl/controller_floatingpoint_mul.sv
// Sequencing FSM for the floating-point multiply datapath: valid/ready request/response
// wrapper, control strobe decode, result capture and saturating op/overflow counters.
module controller_floatingpoint_mul #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic                  mux_en_reg,
  output logic                  inc_shift_en,
  output logic                  enable_reg,
  output logic                  enable_rounding,
  output logic                  mux_en_rounding,
  input  logic                  MLB_significand_mult,
  input  logic                  MLB_exp_inc,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_overflow,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [CNT_WIDTH-1:0]  ovf_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MULT, S_ROUND, S_RENORM, S_WRITE, S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  ovf_q;
  logic [CNT_WIDTH-1:0]  op_cnt_q, ovf_cnt_q;
  logic                  accept;
  logic                  capture;
  logic                  in_flight;

  assign in_flight = (state_q == S_LOAD) || (state_q == S_MULT) || (state_q == S_ROUND) ||
                     (state_q == S_RENORM) || (state_q == S_WRITE);
  assign accept    = (state_q == S_IDLE) && in_valid;
  assign capture   = (state_q == S_WRITE) && !abort;

  always_comb begin
    state_d         = state_q;
    in_ready        = 1'b0;
    A               = '0;
    B               = '0;
    mux_en_reg      = 1'b0;
    inc_shift_en    = 1'b0;
    enable_reg      = 1'b0;
    enable_rounding = 1'b0;
    mux_en_rounding = 1'b0;
    out_valid       = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        A          = a_q;
        B          = b_q;
        enable_reg = 1'b1;
        state_d    = S_MULT;
      end
      S_MULT: begin
        enable_reg   = 1'b1;
        mux_en_reg   = 1'b1;
        inc_shift_en = MLB_significand_mult;
        state_d      = S_ROUND;
      end
      S_ROUND: begin
        enable_rounding = 1'b1;
        state_d         = MLB_exp_inc ? S_RENORM : S_WRITE;
      end
      S_RENORM: begin
        enable_rounding = 1'b1;
        mux_en_rounding = 1'b1;
        state_d         = S_WRITE;
      end
      S_WRITE: begin
        enable_reg = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Cancelling an op in flight overrides every other transition.
    if (in_flight && abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      op_cnt_q  <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (capture) begin
        res_q <= result;
        ovf_q <= overflow_flag;
        if (op_cnt_q != '1) op_cnt_q <= op_cnt_q + CNT_ONE;
        if (overflow_flag && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + CNT_ONE;
      end
    end
  end

  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign op_count     = op_cnt_q;
  assign ovf_count    = ovf_cnt_q;

endmodule
